// File: rtl/free_list_superscalar.sv
// free_list_superscalar: multi-port physical register free list with one branch checkpoint
module free_list_superscalar #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_ARCH_REGS = 32,
    parameter int DEQ_WIDTH     = 2,
    parameter int ENQ_WIDTH     = 2,
    parameter int LOG_PHYS      = $clog2(NUM_PHYS_REGS),
    parameter int DW            = $clog2(DEQ_WIDTH + 1)
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [ENQ_WIDTH-1:0]          Enqueue_IN,
    input  logic [ENQ_WIDTH*LOG_PHYS-1:0] Data_IN,
    input  logic [DW-1:0]                 DequeueCount_IN,
    input  logic                          Checkpoint_IN,
    input  logic                          Restore_IN,
    output logic                          DequeueResult_OUT,
    output logic [DEQ_WIDTH*LOG_PHYS-1:0] Data_OUT,
    output logic [LOG_PHYS:0]             FreeCount_OUT,
    output logic                          Overflow_OUT
);
    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = LOG_PHYS + 1;
    localparam logic [PW:0] DEPTH_P = DEPTH[PW:0];
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
    localparam logic [CW-1:0] DEQ_C = DEQ_WIDTH[CW-1:0];

    // Pointer advance with wrap by compare so DEPTH need not be a power of two
    function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] p, input logic [PW:0] off);
        logic [PW:0] s;
        s = {1'b0, p} + off;
        if (s >= DEPTH_P) s = s - DEPTH_P;
        return s[PW-1:0];
    endfunction

    logic [LOG_PHYS-1:0]           r_queue [DEPTH];
    logic [PW-1:0]                 r_head;
    logic [PW-1:0]                 r_tail;
    logic [PW-1:0]                 r_ckpt_head;
    logic                          r_ckpt_valid;
    logic [CW-1:0]                 r_count;
    logic [CW-1:0]                 r_spec_cnt;
    logic                          r_result;
    logic                          r_overflow;
    logic [DEQ_WIDTH*LOG_PHYS-1:0] r_data;

    logic [CW-1:0]        w_k;
    logic [CW-1:0]        w_grant_k;
    logic [CW-1:0]        w_m;
    logic [CW-1:0]        w_base;
    logic                 w_grant;
    logic                 w_accept;
    logic [PW:0]          w_off;
    logic [PW-1:0]        w_tail_next;
    logic [PW-1:0]        w_head_adv;
    logic [PW-1:0]        w_wr_idx [ENQ_WIDTH];
    logic [ENQ_WIDTH-1:0] w_we;
    logic [PW-1:0]        w_rd_idx [DEQ_WIDTH];
    logic [DEQ_WIDTH-1:0] w_rd_en;

    // Grant decision uses start-of-cycle count; frees are compacted onto the tail and
    // dropped as a whole if they would overfill the list
    always_comb begin
        w_k = CW'(DequeueCount_IN);
        w_grant = !Restore_IN && (w_k != '0) && (w_k <= DEQ_C) && (w_k <= r_count);
        w_grant_k = w_grant ? w_k : '0;
        w_head_adv = f_wrap(r_head, w_grant_k[PW:0]);
        w_base = r_count - w_grant_k + (Restore_IN ? r_spec_cnt : '0);
        w_m = '0;
        w_off = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            w_wr_idx[i] = f_wrap(r_tail, w_off);
            w_off = w_off + (PW + 1)'(Enqueue_IN[i]);
            w_m = w_m + CW'(Enqueue_IN[i]);
        end
        w_tail_next = f_wrap(r_tail, w_off);
        w_accept = (w_base + w_m) <= DEPTH_C;
        w_we = w_accept ? Enqueue_IN : '0;
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            w_rd_idx[j] = f_wrap(r_head, j[PW:0]);
            w_rd_en[j] = w_grant && (j[CW-1:0] < w_k);
        end
    end

    // List storage: preloaded with the unmapped registers, written by accepted frees
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < DEPTH; k++) r_queue[k] <= LOG_PHYS'(NUM_ARCH_REGS + k);
        end else begin
            for (int i = 0; i < ENQ_WIDTH; i++)
                if (w_we[i]) r_queue[w_wr_idx[i]] <= Data_IN[i*LOG_PHYS +: LOG_PHYS];
        end
    end

    // Pointers, occupancy, checkpoint and sticky overflow
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= DEPTH_C;
            r_ckpt_head  <= '0;
            r_ckpt_valid <= 1'b0;
            r_spec_cnt   <= '0;
            r_result     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_head       <= Restore_IN ? r_ckpt_head : w_head_adv;
            r_tail       <= w_accept ? w_tail_next : r_tail;
            r_count      <= w_accept ? w_base + w_m : w_base;
            r_ckpt_head  <= (Checkpoint_IN && !Restore_IN) ? r_head : r_ckpt_head;
            r_ckpt_valid <= r_ckpt_valid | (Checkpoint_IN && !Restore_IN);
            r_spec_cnt   <= Restore_IN ? '0 :
                            Checkpoint_IN ? w_grant_k :
                            r_ckpt_valid ? r_spec_cnt + w_grant_k : r_spec_cnt;
            r_result     <= w_grant;
            r_overflow   <= r_overflow | !w_accept;
        end
    end

    // Granted registers; lanes not granted keep their previous value
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_data <= '0;
        end else begin
            for (int j = 0; j < DEQ_WIDTH; j++)
                if (w_rd_en[j]) r_data[j*LOG_PHYS +: LOG_PHYS] <= r_queue[w_rd_idx[j]];
        end
    end

    assign DequeueResult_OUT = r_result;
    assign Data_OUT          = r_data;
    assign FreeCount_OUT     = r_count;
    assign Overflow_OUT      = r_overflow;
endmodule

// File: tb/tb_free_list_superscalar.sv
// tb_free_list_superscalar: directed table and sequence checks of the free list
module tb_free_list_superscalar;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [1:0]  Enqueue_IN = '0;
    logic [11:0] Data_IN = '0;
    logic [1:0]  DequeueCount_IN = '0;
    logic        Checkpoint_IN = 1'b0;
    logic        Restore_IN = 1'b0;
    logic        DequeueResult_OUT;
    logic [11:0] Data_OUT;
    logic [6:0]  FreeCount_OUT;
    logic        Overflow_OUT;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  enq;
        logic [5:0]  d0;
        logic [5:0]  d1;
        logic [1:0]  deq;
        logic        ck;
        logic        rs;
        logic        res;
        logic [11:0] data;
        logic [6:0]  cnt;
        logic        ovf;
    } vec_t;

    vec_t tbl [15];

    free_list_superscalar dut (
        .CLK(CLK), .RESET(RESET), .Enqueue_IN(Enqueue_IN), .Data_IN(Data_IN),
        .DequeueCount_IN(DequeueCount_IN), .Checkpoint_IN(Checkpoint_IN), .Restore_IN(Restore_IN),
        .DequeueResult_OUT(DequeueResult_OUT), .Data_OUT(Data_OUT),
        .FreeCount_OUT(FreeCount_OUT), .Overflow_OUT(Overflow_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [11:0] pk(input int l0, input int l1);
        logic [5:0] a;
        logic [5:0] b;
        a = l0[5:0];
        b = l1[5:0];
        return {b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic res, input logic [11:0] data,
                             input logic [6:0] cnt, input logic ovf);
        chk({tag, " result"}, 32'(DequeueResult_OUT), 32'(res));
        chk({tag, " data"}, 32'(Data_OUT), 32'(data));
        chk({tag, " count"}, 32'(FreeCount_OUT), 32'(cnt));
        chk({tag, " overflow"}, 32'(Overflow_OUT), 32'(ovf));
    endtask

    task automatic step(input logic [1:0] enq, input logic [5:0] d0, input logic [5:0] d1,
                        input logic [1:0] deq, input logic ck, input logic rs);
        Enqueue_IN = enq;
        Data_IN = {d1, d0};
        DequeueCount_IN = deq;
        Checkpoint_IN = ck;
        Restore_IN = rs;
        @(posedge CLK);
        #1;
        Enqueue_IN = '0;
        Data_IN = '0;
        DequeueCount_IN = '0;
        Checkpoint_IN = 1'b0;
        Restore_IN = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        int mq[$];
        int pq[$];
        int k;
        int g;
        int e0;
        int e1;
        logic [1:0] m;
        logic [11:0] ed;

        //          enq    d0  d1  deq   ck    rs    res   data         cnt ovf
        tbl[0]  = '{2'b00, 0,  0,  2'd0, 1'b0, 1'b0, 1'b0, 12'd0,       32, 1'b0};
        tbl[1]  = '{2'b00, 0,  0,  2'd2, 1'b0, 1'b0, 1'b1, pk(32, 33),  30, 1'b0};
        tbl[2]  = '{2'b00, 0,  0,  2'd1, 1'b0, 1'b0, 1'b1, pk(34, 33),  29, 1'b0};
        tbl[3]  = '{2'b00, 0,  0,  2'd0, 1'b0, 1'b0, 1'b0, pk(34, 33),  29, 1'b0};
        tbl[4]  = '{2'b00, 0,  0,  2'd3, 1'b0, 1'b0, 1'b0, pk(34, 33),  29, 1'b0};
        tbl[5]  = '{2'b11, 33, 32, 2'd0, 1'b0, 1'b0, 1'b0, pk(34, 33),  31, 1'b0};
        tbl[6]  = '{2'b00, 0,  0,  2'd2, 1'b0, 1'b0, 1'b1, pk(35, 36),  29, 1'b0};
        tbl[7]  = '{2'b00, 0,  0,  2'd2, 1'b1, 1'b0, 1'b1, pk(37, 38),  27, 1'b0};
        tbl[8]  = '{2'b00, 0,  0,  2'd2, 1'b0, 1'b0, 1'b1, pk(39, 40),  25, 1'b0};
        tbl[9]  = '{2'b00, 0,  0,  2'd2, 1'b0, 1'b1, 1'b0, pk(39, 40),  29, 1'b0};
        tbl[10] = '{2'b00, 0,  0,  2'd2, 1'b0, 1'b0, 1'b1, pk(37, 38),  27, 1'b0};
        tbl[11] = '{2'b01, 34, 0,  2'd0, 1'b0, 1'b1, 1'b0, pk(37, 38),  30, 1'b0};
        tbl[12] = '{2'b00, 0,  0,  2'd1, 1'b0, 1'b0, 1'b1, pk(37, 38),  29, 1'b0};
        tbl[13] = '{2'b00, 0,  0,  2'd0, 1'b1, 1'b1, 1'b0, pk(37, 38),  30, 1'b0};
        tbl[14] = '{2'b00, 0,  0,  2'd2, 1'b0, 1'b0, 1'b1, pk(37, 38),  28, 1'b0};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].enq, tbl[i].d0, tbl[i].d1, tbl[i].deq, tbl[i].ck, tbl[i].rs);
            check_out($sformatf("vec%0d", i), tbl[i].res, tbl[i].data, tbl[i].cnt, tbl[i].ovf);
        end

        // Drain to empty, then frees arriving while empty are not grantable that cycle
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
            check_out($sformatf("drain%0d", i), 1'b1, pk(32 + 2 * i, 33 + 2 * i), 7'(30 - 2 * i), 1'b0);
        end
        step(2'b00, 0, 0, 2'd1, 1'b0, 1'b0);
        check_out("empty_deq", 1'b0, pk(62, 63), 0, 1'b0);
        step(2'b11, 5, 7, 2'd2, 1'b0, 1'b0);
        check_out("empty_enq_deq", 1'b0, pk(62, 63), 2, 1'b0);
        step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
        check_out("refill_deq", 1'b1, pk(5, 7), 0, 1'b0);
        step(2'b10, 0, 9, 2'd0, 1'b0, 1'b0);
        check_out("lane1_enq", 1'b0, pk(5, 7), 1, 1'b0);
        step(2'b00, 0, 0, 2'd1, 1'b0, 1'b0);
        check_out("lane1_deq", 1'b1, pk(9, 7), 0, 1'b0);

        // Checkpoint, speculative allocations, restore
        do_reset();
        step(2'b00, 0, 0, 2'd0, 1'b1, 1'b0);
        check_out("ckpt", 1'b0, 12'd0, 32, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
            check_out($sformatf("spec%0d", i), 1'b1, pk(32 + 2 * i, 33 + 2 * i), 7'(30 - 2 * i), 1'b0);
        end
        step(2'b00, 0, 0, 2'd2, 1'b0, 1'b1);
        check_out("restore", 1'b0, pk(36, 37), 32, 1'b0);
        step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
        check_out("post_restore", 1'b1, pk(32, 33), 30, 1'b0);

        // Restore without any checkpoint since reset: head to 0, count unchanged
        do_reset();
        step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
        check_out("nockpt_deq", 1'b1, pk(32, 33), 30, 1'b0);
        step(2'b00, 0, 0, 2'd0, 1'b0, 1'b1);
        check_out("nockpt_restore", 1'b0, pk(32, 33), 30, 1'b0);
        step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
        check_out("nockpt_after", 1'b1, pk(32, 33), 28, 1'b0);

        // Wrap-around against a FIFO model with mixed dequeue sizes and lane-1-only frees
        do_reset();
        mq = {};
        pq = {};
        for (int i = 0; i < 32; i++) mq.push_back(32 + i);
        ed = '0;
        for (int it = 0; it < 40; it++) begin
            k = (it % 3 == 0) ? 1 : 2;
            m = 2'b00;
            e0 = 0;
            e1 = 0;
            if (pq.size() >= 2) begin
                m = 2'b11;
                e0 = pq.pop_front();
                e1 = pq.pop_front();
            end else if (pq.size() == 1) begin
                m = 2'b10;
                e1 = pq.pop_front();
            end
            step(m, e0[5:0], e1[5:0], k[1:0], 1'b0, 1'b0);
            for (int j = 0; j < k; j++) begin
                g = mq.pop_front();
                ed[j*6 +: 6] = g[5:0];
                pq.push_back(g);
            end
            if (m[0]) mq.push_back(e0);
            if (m[1]) mq.push_back(e1);
            check_out($sformatf("wrap%0d", it), 1'b1, ed, 7'(mq.size()), 1'b0);
        end

        // Overflow is sticky; asynchronous reset mid-cycle clears everything at once
        do_reset();
        step(2'b01, 1, 0, 2'd0, 1'b0, 1'b0);
        check_out("ovf_set", 1'b0, 12'd0, 32, 1'b1);
        step(2'b00, 0, 0, 2'd0, 1'b0, 1'b0);
        check_out("ovf_sticky", 1'b0, 12'd0, 32, 1'b1);
        step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
        check_out("ovf_deq", 1'b1, pk(32, 33), 30, 1'b1);
        DequeueCount_IN = 2'd2;
        #3;
        RESET = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 12'd0, 32, 1'b0);
        DequeueCount_IN = 2'd0;
        #2;
        RESET = 1'b1;
        step(2'b00, 0, 0, 2'd0, 1'b0, 1'b0);
        check_out("post_rst_idle", 1'b0, 12'd0, 32, 1'b0);
        step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
        check_out("post_rst_deq", 1'b1, pk(32, 33), 30, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
